// File: rtl/nonogram_grid_ctrl.sv
// Nonogram player-input front end: synchronises raw buttons, moves a wrapping
// cursor with per-direction auto-repeat, and holds the painted/blocked bitmaps.
module nonogram_grid_ctrl #(
  parameter int GRID_W       = 10,
  parameter int GRID_H       = 10,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_paint,
  input  logic                       btn_block,
  input  logic                       clr_grid,
  input  logic                       lock,
  output logic [3:0]                 sel_x,
  output logic [3:0]                 sel_y,
  output logic [GRID_W*GRID_H-1:0]   paint,
  output logic [GRID_W*GRID_H-1:0]   block,
  output logic                       edit_strobe
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

  localparam logic [CNT_W-1:0] CNT_FIRE   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [3:0]       X_MAX      = 4'(GRID_W - 1);
  localparam logic [3:0]       Y_MAX      = 4'(GRID_H - 1);

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_PAINT = 4;
  localparam int BTN_BLOCK = 5;

  logic [5:0] btn_raw;
  logic [5:0] sync1_q, sync2_q, prev_q;
  logic [5:0] btn_edge;

  logic [CNT_W-1:0] rpt_cnt_q [4];
  logic [CNT_W-1:0] rpt_cnt_d [4];
  logic [3:0]       move_req;

  logic [3:0]       sel_x_q, sel_x_d;
  logic [3:0]       sel_y_q, sel_y_d;
  logic [CELLS-1:0] paint_q, paint_d;
  logic [CELLS-1:0] block_q, block_d;
  logic             strobe_q, strobe_d;

  logic [IDX_W-1:0] cell_idx;
  logic             paint_ev, block_ev;

  assign btn_raw = {btn_block, btn_paint, btn_right, btn_left, btn_down, btn_up};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign btn_edge = sync2_q & ~prev_q;

  // Auto-repeat: a fresh edge restarts the count; holding reaches CNT_FIRE
  // after REPEAT_DELAY cycles, then the reload spaces later moves by REPEAT_RATE.
  // NOTE: every always_comb output gets a default before any branch, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      rpt_cnt_d[d] = '0;
      move_req[d]  = 1'b0;
      if (btn_edge[d]) begin
        move_req[d] = 1'b1;
      end else if (sync2_q[d]) begin
        if (rpt_cnt_q[d] == CNT_FIRE) begin
          move_req[d]  = 1'b1;
          rpt_cnt_d[d] = CNT_RELOAD;
        end else begin
          rpt_cnt_d[d] = rpt_cnt_q[d] + CNT_W'(1);
        end
      end
      if (clr_grid) rpt_cnt_d[d] = '0;
    end
  end

  always_comb begin
    sel_x_d = sel_x_q;
    sel_y_d = sel_y_q;
    if (clr_grid) begin
      sel_x_d = 4'd0;
      sel_y_d = 4'd0;
    end else if (move_req[BTN_UP]) begin
      sel_y_d = (sel_y_q == 4'd0) ? Y_MAX : sel_y_q - 4'd1;
    end else if (move_req[BTN_DOWN]) begin
      sel_y_d = (sel_y_q == Y_MAX) ? 4'd0 : sel_y_q + 4'd1;
    end else if (move_req[BTN_LEFT]) begin
      sel_x_d = (sel_x_q == 4'd0) ? X_MAX : sel_x_q - 4'd1;
    end else if (move_req[BTN_RIGHT]) begin
      sel_x_d = (sel_x_q == X_MAX) ? 4'd0 : sel_x_q + 4'd1;
    end
  end

  // Edits always target the pre-move cursor cell.
  assign cell_idx = IDX_W'(sel_y_q) * IDX_W'(GRID_W) + IDX_W'(sel_x_q);
  assign paint_ev = btn_edge[BTN_PAINT] & ~btn_edge[BTN_BLOCK] & ~lock;
  assign block_ev = btn_edge[BTN_BLOCK] & ~btn_edge[BTN_PAINT] & ~lock;

  // A cell marked one way ignores the other toggle, keeping paint & block disjoint.
  always_comb begin
    paint_d = paint_q;
    block_d = block_q;
    if (clr_grid) begin
      paint_d = '0;
      block_d = '0;
    end else begin
      if (paint_ev && !block_q[cell_idx]) paint_d[cell_idx] = ~paint_q[cell_idx];
      if (block_ev && !paint_q[cell_idx]) block_d[cell_idx] = ~block_q[cell_idx];
    end
  end

  assign strobe_d = (paint_d != paint_q) || (block_d != block_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) rpt_cnt_q[d] <= '0;
      sel_x_q  <= 4'd0;
      sel_y_q  <= 4'd0;
      paint_q  <= '0;
      block_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      for (int d = 0; d < 4; d++) rpt_cnt_q[d] <= rpt_cnt_d[d];
      sel_x_q  <= sel_x_d;
      sel_y_q  <= sel_y_d;
      paint_q  <= paint_d;
      block_q  <= block_d;
      strobe_q <= strobe_d;
    end
  end

  assign sel_x       = sel_x_q;
  assign sel_y       = sel_y_q;
  assign paint       = paint_q;
  assign block       = block_q;
  assign edit_strobe = strobe_q;

endmodule
